// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 control FSM: steps the datapath through fetch, decode, execute, memory and
// writeback, with run/pause/single-step, handshake timeouts, traps and debug counters.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [6:0]       opcode,
  input  logic             insn_ack,
  input  logic             mem_ack,
  output logic             insn_req,
  output logic             ir_en,
  output logic             mem_req,
  output logic             mem_we,
  output logic             reg_write_en,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StFetch     = 3'd1,
    StDecode    = 3'd2,
    StExecute   = 3'd3,
    StMemory    = 3'd4,
    StWriteback = 3'd5,
    StTrap      = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic [1:0]        cause_q, cause_d;
  logic [CNT_W-1:0]  cyc_q, ret_q;
  logic              retire;
  logic              is_alu, is_load, is_store, is_branch, legal, timed_out;

  always_comb begin
    is_alu    = opcode inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b1101111};
    is_load   = (opcode == 7'b0000011);
    is_store  = (opcode == 7'b0100011);
    is_branch = (opcode == 7'b1100011);
    legal     = is_alu | is_load | is_store | is_branch;
  end

  // Fires on the MEM_TIMEOUT-th consecutive wait cycle; a coincident ack takes priority.
  assign timed_out = (MEM_TIMEOUT != 0) && (to_q == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    insn_req     = 1'b0;
    ir_en        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    reg_write_en = 1'b0;
    pc_en        = 1'b0;
    retire       = 1'b0;
    case (state_q)
      StIdle: begin
        if (run || step) state_d = StFetch;
      end
      StFetch: begin
        insn_req = 1'b1;
        if (insn_ack) begin
          ir_en   = 1'b1;
          state_d = StDecode;
        end else if (timed_out) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end
      end
      StDecode: begin
        if (!legal) begin
          state_d = StTrap;
          cause_d = 2'd1;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        if (is_load || is_store) begin
          state_d = StMemory;
        end else if (is_branch) begin
          pc_en  = 1'b1;
          retire = 1'b1;
        end else begin
          state_d = StWriteback;
        end
      end
      StMemory: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (mem_ack) begin
          if (is_store) begin
            pc_en  = 1'b1;
            retire = 1'b1;
          end else begin
            state_d = StWriteback;
          end
        end else if (timed_out) begin
          state_d = StTrap;
          cause_d = 2'd3;
        end
      end
      StWriteback: begin
        reg_write_en = 1'b1;
        pc_en        = 1'b1;
        retire       = 1'b1;
      end
      StTrap: ;
      default: state_d = StIdle;
    endcase
    if (retire) state_d = run ? StFetch : StIdle;
    // Any state change restarts the wait counter, so entry to FETCH/MEMORY always sees zero.
    to_d = (state_d != state_q) ? '0 : to_q + TO_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      to_q    <= '0;
      cause_q <= 2'd0;
      cyc_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      to_q    <= to_d;
      cause_q <= cause_d;
      if (state_q != StIdle && state_q != StTrap) cyc_q <= cyc_q + CNT_W'(1);
      if (retire) ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign state         = state_q;
  assign halted        = (state_q == StIdle);
  assign trap          = (state_q == StTrap);
  assign trap_cause    = cause_q;
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: expected retire records are queued at issue and
// checked when pc_en fires; per-scenario tasks check states, strobes, counters and traps.
module tb_multicycle_sequencer;

  localparam int unsigned MemTimeout = 4;
  localparam int unsigned CntW       = 32;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpBad    = 7'b0000000;

  logic            clk = 1'b0;
  logic            reset, run, step, insn_ack, mem_ack;
  logic [6:0]      opcode;
  logic            insn_req, ir_en, mem_req, mem_we, reg_write_en, pc_en;
  logic [2:0]      state;
  logic            halted, trap;
  logic [1:0]      trap_cause;
  logic [CntW-1:0] cycle_count, retired_count;

  typedef struct packed {
    logic [2:0] st;
    logic       rwe;
    logic       we;
  } retire_t;

  retire_t exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .MEM_TIMEOUT(MemTimeout),
    .CNT_W      (CntW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .step         (step),
    .opcode       (opcode),
    .insn_ack     (insn_ack),
    .mem_ack      (mem_ack),
    .insn_req     (insn_req),
    .ir_en        (ir_en),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .reg_write_en (reg_write_en),
    .pc_en        (pc_en),
    .state        (state),
    .halted       (halted),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .cycle_count  (cycle_count),
    .retired_count(retired_count)
  );

  task automatic do_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    insn_ack = 1'b0; mem_ack = 1'b0; opcode = OpR;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; step = 1'b0;
    insn_ack = 1'b0; mem_ack = 1'b0; opcode = OpR;
    @(negedge clk);
    total++;
    if (state !== 3'd0 || halted !== 1'b1 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      bad++;
      $display("FAIL reset_state: state=%0d halted=%b trap=%b cause=%0d want 0/1/0/0",
               state, halted, trap, trap_cause);
    end
    total++;
    if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_counts: cyc=%0d ret=%0d want 0/0", cycle_count, retired_count);
    end
    total++;
    if ({insn_req, ir_en, mem_req, mem_we, reg_write_en, pc_en} !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes: got=%b want=000000",
               {insn_req, ir_en, mem_req, mem_we, reg_write_en, pc_en});
    end
  endtask

  // R-type with run held high: exact state walk and strobe timing.
  task automatic test_alu_seq();
    logic [2:0] seq [4];
    retire_t got, e;
    seq = '{3'd1, 3'd2, 3'd3, 3'd5};
    do_reset();
    run = 1'b1; insn_ack = 1'b1; opcode = OpR;
    exp_q.push_back('{3'd5, 1'b1, 1'b0});
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (state !== seq[k] || {reg_write_en, pc_en} !== ((k == 3) ? 2'b11 : 2'b00)
          || {insn_req, ir_en} !== ((k == 0) ? 2'b11 : 2'b00)) begin
        bad++;
        $display("FAIL alu_seq[%0d]: state=%0d rwe/pc=%b req/ir=%b want state=%0d", k, state,
                 {reg_write_en, pc_en}, {insn_req, ir_en}, seq[k]);
      end
      if (pc_en) begin
        total++;
        got = '{state, reg_write_en, mem_we};
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL alu_seq_retire: unexpected retire got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++; $display("FAIL alu_seq_retire: got=%h want=%h", got, e);
          end
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (state !== 3'd1 || retired_count !== 32'd1 || cycle_count !== 32'd4) begin
      bad++;
      $display("FAIL alu_seq_after: state=%0d ret=%0d cyc=%0d want 1/1/4",
               state, retired_count, cycle_count);
    end
    run = 1'b0; insn_ack = 1'b0;
  endtask

  // One instruction issued by a one-cycle run or step pulse, with given ack latencies.
  task automatic test_insn(input logic [6:0] op, input int fd, input int md,
                           input logic by_step, input string name);
    retire_t e, got, ex;
    int nf, nm, nrwe, nm_exp, rwe_exp, cyc_exp;
    logic we_seen, done;
    do_reset();
    opcode = op;
    if (op == OpStore) begin
      e = '{3'd4, 1'b0, 1'b1}; nm_exp = md + 1; rwe_exp = 0; cyc_exp = fd + 1 + 2 + md + 1;
    end else if (op == OpLoad) begin
      e = '{3'd5, 1'b1, 1'b0}; nm_exp = md + 1; rwe_exp = 1; cyc_exp = fd + 1 + 2 + md + 1 + 1;
    end else if (op == OpBranch) begin
      e = '{3'd3, 1'b0, 1'b0}; nm_exp = 0; rwe_exp = 0; cyc_exp = fd + 1 + 2;
    end else begin
      e = '{3'd5, 1'b1, 1'b0}; nm_exp = 0; rwe_exp = 1; cyc_exp = fd + 1 + 3;
    end
    exp_q.push_back(e);
    if (by_step) step = 1'b1; else run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0; step = 1'b0;
    nf = 0; nm = 0; nrwe = 0; we_seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      insn_ack = (nf == fd);
      mem_ack  = (nm == md);
      @(negedge clk);
      if (state == 3'd1) nf++;
      if (mem_req) begin nm++; we_seen = we_seen | mem_we; end
      if (reg_write_en) nrwe++;
      if (pc_en) begin
        total++;
        got = '{state, reg_write_en, mem_we};
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL %s_retire: unexpected retire got=%h", name, got);
        end else begin
          ex = exp_q.pop_front();
          if (got !== ex) begin
            bad++; $display("FAIL %s_retire: got=%h want=%h", name, got, ex);
          end
        end
      end
      if (halted) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    insn_ack = 1'b0; mem_ack = 1'b0;
    total++;
    if (!done || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_done: halted=%b pending=%0d want halted=1 pending=0", name, done,
               exp_q.size());
    end
    total++;
    if (nf != fd + 1 || nm != nm_exp || nrwe != rwe_exp || we_seen !== (op == OpStore)) begin
      bad++;
      $display("FAIL %s_strobes: fetch=%0d mem=%0d rwe=%0d we=%b want %0d/%0d/%0d/%b", name,
               nf, nm, nrwe, we_seen, fd + 1, nm_exp, rwe_exp, op == OpStore);
    end
    total++;
    if (retired_count !== 32'd1 || cycle_count !== 32'(cyc_exp)) begin
      bad++;
      $display("FAIL %s_counts: ret=%0d cyc=%0d want 1/%0d", name, retired_count, cycle_count,
               cyc_exp);
    end
  endtask

  // Continuous run with step pulses sprinkled in: throughput must be unaffected.
  task automatic test_back_to_back();
    retire_t got, e;
    do_reset();
    run = 1'b1; insn_ack = 1'b1; opcode = OpR;
    for (int i = 0; i < 5; i++) exp_q.push_back('{3'd5, 1'b1, 1'b0});
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      step = (c % 3 == 0);
      @(negedge clk);
      if (pc_en) begin
        total++;
        got = '{state, reg_write_en, mem_we};
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_retire: unexpected retire got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            bad++; $display("FAIL b2b_retire: got=%h want=%h", got, e);
          end
        end
      end
    end
    step = 1'b0;
    total++;
    if (retired_count !== 32'd5 || cycle_count !== 32'd20 || state !== 3'd1
        || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_counts: ret=%0d cyc=%0d state=%0d pending=%0d want 5/20/1/0",
               retired_count, cycle_count, state, exp_q.size());
    end
    run = 1'b0; insn_ack = 1'b0;
  endtask

  task automatic test_illegal();
    do_reset();
    run = 1'b1; insn_ack = 1'b1; opcode = OpBad;
    repeat (3) @(posedge clk);
    #1 insn_ack = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      total++;
      if (state !== 3'd7 || trap !== 1'b1 || trap_cause !== 2'd1 || cycle_count !== 32'd2
          || {insn_req, ir_en, mem_req, mem_we, reg_write_en, pc_en} !== 6'b0) begin
        bad++;
        $display("FAIL illegal[%0d]: state=%0d trap=%b cause=%0d cyc=%0d want 7/1/1/2", c,
                 state, trap, trap_cause, cycle_count);
      end
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (state !== 3'd0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      bad++;
      $display("FAIL illegal_clear: state=%0d trap=%b cause=%0d want 0/0/0", state, trap,
               trap_cause);
    end
  endtask

  task automatic test_timeout();
    int nf, nm;
    // Fetch never acknowledged.
    do_reset();
    run = 1'b1; nf = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (state == 3'd1) nf++;
      if (state == 3'd7) break;
    end
    total++;
    if (state !== 3'd7 || nf != 4 || trap_cause !== 2'd2) begin
      bad++;
      $display("FAIL fetch_timeout: state=%0d waits=%0d cause=%0d want 7/4/2", state, nf,
               trap_cause);
    end
    // Ack lands on the last allowed wait cycle, then the load's data ack never comes.
    do_reset();
    run = 1'b1; opcode = OpLoad; nf = 0;
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) begin
      insn_ack = (nf == 3);
      @(negedge clk);
      if (state == 3'd1) nf++;
      @(posedge clk); #1;
      if (state != 3'd1) break;
    end
    insn_ack = 1'b0;
    @(negedge clk);
    total++;
    if (state !== 3'd2 || nf != 4 || trap !== 1'b0) begin
      bad++;
      $display("FAIL fetch_ack_wins: state=%0d waits=%0d trap=%b want 2/4/0", state, nf, trap);
    end
    nm = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_req) nm++;
      if (state == 3'd7) break;
    end
    total++;
    if (state !== 3'd7 || nm != 4 || trap_cause !== 2'd3) begin
      bad++;
      $display("FAIL data_timeout: state=%0d waits=%0d cause=%0d want 7/4/3", state, nm,
               trap_cause);
    end
    // Reset mid-MEMORY drops the request without waiting for a clock edge.
    do_reset();
    run = 1'b1; insn_ack = 1'b1; opcode = OpStore;
    repeat (4) @(posedge clk);
    @(negedge clk);
    total++;
    if (state !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b1) begin
      bad++;
      $display("FAIL store_mem: state=%0d req=%b we=%b want 4/1/1", state, mem_req, mem_we);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || state !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: req=%b we=%b state=%0d want 0/0/0", mem_req, mem_we, state);
    end
  endtask

  initial begin
    test_reset();
    test_alu_seq();
    test_insn(OpR,      0, 0, 1'b0, "r_run");
    test_insn(OpI,      2, 0, 1'b0, "i_fetchlat");
    test_insn(OpLoad,   0, 3, 1'b0, "load");
    test_insn(OpStore,  1, 1, 1'b0, "store");
    test_insn(OpBranch, 1, 0, 1'b0, "branch");
    test_insn(OpJal,    0, 0, 1'b1, "jal_step");
    test_insn(OpLoad,   0, 0, 1'b1, "load_step");
    test_back_to_back();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that steps the RV32 datapath (PC, instruction memory, decoder, register file, ALU, data memory) through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, one instruction at a time.
- Handshakes with instruction and data memory that have variable latency.
- Supports run, pause and single-step.
- Traps on illegal opcodes and on memory timeouts, and keeps cycle and retired-instruction counters for the debug/testbench harness.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for insn_ack/mem_ack before trap; 0 disables timeout.
- CNT_W, 32: width of cycle_count and retired_count.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  level; 1 = free-run, 0 = pause at next instruction boundary.
- step  input  1  one-cycle pulse; executes exactly one instruction while paused.
- opcode  input  7  insn[6:0] from decoder.
- insn_ack  input  1  instruction memory data valid.
- mem_ack  input  1  data memory access complete.
- insn_req  output  1  instruction fetch request.
- ir_en  output  1  latch fetched instruction.
- mem_req  output  1  data memory request.
- mem_we  output  1  data memory write (valid with mem_req).
- reg_write_en  output  1  register file write strobe.
- pc_en  output  1  PC update strobe.
- state  output  3  current FSM state.
- halted  output  1  FSM in IDLE.
- trap  output  1  FSM in TRAP.
- trap_cause  output  2  0 none, 1 illegal opcode, 2 fetch timeout, 3 data timeout.
- cycle_count  output  CNT_W  active cycles.
- retired_count  output  CNT_W  retired instructions.

Behaviour:
- Reset (reset=0, async): state=IDLE, counters=0, trap_cause=0, all strobes 0, halted=1.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=7. Codes 6 and any illegal state recover to IDLE on the next clock.
- Opcode classes:
  - R=0110011, I=0010011, JALR=1100111, JAL=1101111 → ALU class.
  - LOAD=0000011, STORE=0100011.
  - BRANCH=1100011.
  - Any other value is illegal.
- IDLE: if run=1 or step=1, go to FETCH. step is ignored when run=1.
- FETCH: insn_req=1. When insn_ack=1, ir_en=1 in the same cycle (Mealy) and next state is DECODE.
- DECODE: one cycle, all strobes 0. Illegal opcode goes to TRAP with cause 1; otherwise EXECUTE.
- EXECUTE: one cycle.
  - LOAD/STORE go to MEMORY.
  - ALU class goes to WRITEBACK.
  - BRANCH retires here: pc_en=1 this cycle.
- MEMORY: mem_req=1, mem_we=1 only for STORE; both held until mem_ack=1.
  - On ack, LOAD goes to WRITEBACK.
  - On ack, STORE retires with pc_en=1 in the ack cycle.
- WRITEBACK: reg_write_en=1 and pc_en=1 for one cycle, then retire.
- Retire: retired_count+1; next state is FETCH if run=1, else IDLE. A step-initiated instruction always returns to IDLE unless run has since risen.
- Opcode sampling: opcode is sampled in DECODE, EXECUTE and MEMORY. The datapath holds the instruction register stable until the next ir_en.
- Timeout counter:
  - Cleared on entry to FETCH/MEMORY; increments each cycle waiting without ack.
  - If it reaches MEM_TIMEOUT with no ack, go to TRAP with cause 2 (FETCH) or 3 (MEMORY).
  - If ack and timeout coincide, ack wins.
- TRAP: all strobes 0, trap=1, trap_cause held. Exits only by reset.
- cycle_count: +1 every clock with state not IDLE and not TRAP. Wraps modulo 2^CNT_W.
- retired_count: wraps modulo 2^CNT_W.
- run deasserted mid-instruction: the instruction completes, then IDLE; no partial strobes are suppressed.
- Reset asserted mid-MEMORY: mem_req drops immediately (async); the write is not guaranteed.
- At most one of pc_en/reg_write_en edges per instruction; never more than one retire per instruction.

Test Plan:
- Reset release, run=1, R-type opcode, insn_ack in the 1st FETCH cycle → state seq 1,2,3,5,1; reg_write_en and pc_en high in cycle 4 only; retired_count=1 and cycle_count=4 after retire.
- LOAD with mem_ack delayed 3 cycles → mem_req high 4 cycles, mem_we=0, then WRITEBACK with reg_write_en=1; STORE → mem_we=1, pc_en in ack cycle, no reg_write_en.
- BRANCH → pc_en in EXECUTE; next state FETCH; 3 states per instruction plus fetch latency.
- run=0, single step pulse from IDLE → exactly one instruction retires, returns to IDLE, halted=1, retired_count+1; a step pulse during run=1 has no effect.
- opcode=0000000 → TRAP, trap_cause=1, strobes 0 for 20 cycles; cycle_count frozen; reset clears the trap.
- MEM_TIMEOUT=4, no insn_ack → TRAP cause 2 after 4 wait cycles; insn_ack coinciding with the 4th wait cycle → DECODE, no trap.
